// File: rtl/window_address_decoder_pkg.sv
// Shared constants for the programmable window decoder: device IDs,
// config block placement, register offsets and ctrl field positions.
package window_address_decoder_pkg;

    localparam int BUS_ID_WIDTH = 4;

    localparam logic [3:0] SRAM_ID  = 4'd0;
    localparam logic [3:0] UART_ID  = 4'd1;
    localparam logic [3:0] SPI_ID   = 4'd2;
    localparam logic [3:0] VIA_ID   = 4'd3;

    localparam logic [3:0]  CFG_ID_DEFAULT   = 4'd15;
    localparam logic [15:0] CFG_BASE_DEFAULT = 16'hE1F0;

    // Byte offsets inside one 8-byte window register group
    localparam logic [2:0] OFF_BASE_HI = 3'd0;
    localparam logic [2:0] OFF_BASE_LO = 3'd1;
    localparam logic [2:0] OFF_MASK_HI = 3'd2;
    localparam logic [2:0] OFF_MASK_LO = 3'd3;
    localparam logic [2:0] OFF_CTRL    = 3'd4;

    // ctrl byte layout: enable | wait states | device ID
    localparam int CTRL_EN_BIT = 7;
    localparam int CTRL_WS_LSB = 4;
    localparam int CTRL_ID_LSB = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wait_state_t;

endpackage

// File: rtl/window_address_decoder_if.sv
// CPU-side bus bundle between the 6502 and the window decoder.
interface window_address_decoder_if
    import window_address_decoder_pkg::*;
#(
    parameter int ID_WIDTH = BUS_ID_WIDTH
);
    logic [15:0]              address_bus;
    logic                     rwb;
    logic [7:0]               data_in;
    logic [7:0]               data_out;
    logic [(2**ID_WIDTH)-1:0] enable_lines;
    logic [ID_WIDTH-1:0]      active_bus_device_id;
    logic                     rdy;

    modport master (
        output address_bus, rwb, data_in,
        input  data_out, enable_lines, active_bus_device_id, rdy
    );

    modport slave (
        input  address_bus, rwb, data_in,
        output data_out, enable_lines, active_bus_device_id, rdy
    );
endinterface

// File: rtl/window_address_decoder_window_match.sv
// One programmable window: base/mask/ctrl registers, the match comparator
// and readback of the addressed register byte.
module window_address_decoder_window_match
    import window_address_decoder_pkg::*;
#(
    parameter int ID_WIDTH = 4,
    parameter int WS_WIDTH = 3
)(
    input  logic                phi2,
    input  logic                reset,
    input  logic                i_we,
    input  logic [2:0]          i_offset,
    input  logic [7:0]          i_wdata,
    input  logic [15:0]         i_address,
    output logic                o_match,
    output logic [WS_WIDTH-1:0] o_ws,
    output logic [ID_WIDTH-1:0] o_id,
    output logic [7:0]          o_rdata
);

    logic [15:0] r_base;
    logic [15:0] r_mask;
    logic [7:0]  r_ctrl;

    // Load the addressed register byte on a config write; offsets 5..7 are ignored
    always_ff @(posedge phi2) begin
        if (reset) begin
            r_base <= '0;
            r_mask <= '0;
            r_ctrl <= '0;
        end else if (i_we) begin
            case (i_offset)
                OFF_BASE_HI: r_base[15:8] <= i_wdata;
                OFF_BASE_LO: r_base[7:0]  <= i_wdata;
                OFF_MASK_HI: r_mask[15:8] <= i_wdata;
                OFF_MASK_LO: r_mask[7:0]  <= i_wdata;
                OFF_CTRL:    r_ctrl       <= i_wdata;
                default:     ;
            endcase
        end
    end

    assign o_match = r_ctrl[CTRL_EN_BIT] && ((i_address & r_mask) == (r_base & r_mask));
    assign o_ws    = r_ctrl[CTRL_WS_LSB +: WS_WIDTH];
    assign o_id    = r_ctrl[CTRL_ID_LSB +: ID_WIDTH];

    // Present the register byte selected by the low address bits
    always_comb begin
        o_rdata = 8'h00;
        case (i_offset)
            OFF_BASE_HI: o_rdata = r_base[15:8];
            OFF_BASE_LO: o_rdata = r_base[7:0];
            OFF_MASK_HI: o_rdata = r_mask[15:8];
            OFF_MASK_LO: o_rdata = r_mask[7:0];
            OFF_CTRL:    o_rdata = r_ctrl;
            default:     o_rdata = 8'h00;
        endcase
    end

endmodule

// File: rtl/window_address_decoder.sv
// Programmable 6502 address decoder: N base/mask windows with priority,
// one-hot enables, config readback and a wait-state FSM driving RDY.
module window_address_decoder
    import window_address_decoder_pkg::*;
#(
    parameter int                       N_WINDOWS  = 4,
    parameter int                       ID_WIDTH   = BUS_ID_WIDTH,
    parameter int unsigned              DEFAULT_ID = 32'(SRAM_ID),
    parameter int unsigned              CFG_ID     = 32'(CFG_ID_DEFAULT),
    parameter logic [15:0]              CFG_BASE   = CFG_BASE_DEFAULT,
    parameter int                       WS_WIDTH   = 3,
    parameter logic [(2**ID_WIDTH)-1:0] GATED_IDS  = {{((2**ID_WIDTH)-1){1'b0}}, 1'b1}
)(
    input  logic                      phi2,
    input  logic                      reset,
    window_address_decoder_if.slave   bus
);

    localparam int CFG_BYTES = 8 * N_WINDOWS;

    logic [15:0]          w_cfg_off;
    logic                 w_in_cfg;
    logic [12:0]          w_cfg_win;
    logic                 w_cfg_we;
    logic [N_WINDOWS-1:0] w_match;
    logic [WS_WIDTH-1:0]  w_win_ws    [N_WINDOWS];
    logic [ID_WIDTH-1:0]  w_win_id    [N_WINDOWS];
    logic [7:0]           w_win_rdata [N_WINDOWS];
    logic [ID_WIDTH-1:0]  w_sel_id;
    logic [WS_WIDTH-1:0]  w_sel_ws;
    logic [7:0]           w_dout;
    logic [(2**ID_WIDTH)-1:0] w_enable;

    wait_state_t          r_state, w_state_nxt;
    logic [WS_WIDTH-1:0]  r_cnt, w_cnt_nxt;
    logic                 r_rdy, w_rdy_nxt;
    logic [15:0]          r_last_addr, w_last_addr_nxt;
    logic [ID_WIDTH-1:0]  r_last_id, w_last_id_nxt;
    logic                 r_last_valid, w_last_valid_nxt;
    logic [15:0]          r_stall_addr, w_stall_addr_nxt;
    logic                 w_new_access;

    // Offset subtraction keeps the range check correct even if CFG_BASE is not aligned
    assign w_cfg_off = bus.address_bus - CFG_BASE;
    assign w_in_cfg  = (w_cfg_off < 16'(CFG_BYTES));
    assign w_cfg_win = w_cfg_off[15:3];
    assign w_cfg_we  = w_in_cfg && !bus.rwb && r_rdy;

    for (genvar g = 0; g < N_WINDOWS; g++) begin : g_win
        window_address_decoder_window_match #(
            .ID_WIDTH (ID_WIDTH),
            .WS_WIDTH (WS_WIDTH)
        ) u_window (
            .phi2      (phi2),
            .reset     (reset),
            .i_we      (w_cfg_we && (w_cfg_win == 13'(g))),
            .i_offset  (w_cfg_off[2:0]),
            .i_wdata   (bus.data_in),
            .i_address (bus.address_bus),
            .o_match   (w_match[g]),
            .o_ws      (w_win_ws[g]),
            .o_id      (w_win_id[g]),
            .o_rdata   (w_win_rdata[g])
        );
    end

    // Priority select: config block first, then lowest matching window, else the default device
    always_comb begin
        w_sel_id = ID_WIDTH'(DEFAULT_ID);
        w_sel_ws = '0;
        for (int w = N_WINDOWS - 1; w >= 0; w--) begin
            if (w_match[w]) begin
                w_sel_id = w_win_id[w];
                w_sel_ws = w_win_ws[w];
            end
        end
        if (w_in_cfg) begin
            w_sel_id = ID_WIDTH'(CFG_ID);
            w_sel_ws = '0;
        end
    end

    // Readback mux: the addressed window's byte, zero outside the config block
    always_comb begin
        w_dout = 8'h00;
        for (int w = 0; w < N_WINDOWS; w++) begin
            if (w_in_cfg && (w_cfg_win == 13'(w))) begin
                w_dout = w_win_rdata[w];
            end
        end
    end

    // One-hot enables; gated devices only see their enable while phi2 is high
    always_comb begin
        w_enable = '0;
        for (int k = 0; k < 2**ID_WIDTH; k++) begin
            w_enable[k] = (w_sel_id == ID_WIDTH'(k)) && (!GATED_IDS[k] || phi2);
        end
    end

    assign bus.data_out             = w_dout;
    assign bus.enable_lines         = w_enable;
    assign bus.active_bus_device_id = w_sel_id;
    assign bus.rdy                  = r_rdy;

    // Wait-state FSM state register; reset releases RDY immediately
    always_ff @(posedge phi2) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_rdy        <= 1'b1;
            r_last_addr  <= '0;
            r_last_id    <= '0;
            r_last_valid <= 1'b0;
            r_stall_addr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rdy        <= w_rdy_nxt;
            r_last_addr  <= w_last_addr_nxt;
            r_last_id    <= w_last_id_nxt;
            r_last_valid <= w_last_valid_nxt;
            r_stall_addr <= w_stall_addr_nxt;
        end
    end

    // Stall only on the first cycle of a new access; the held address after a stall must not restart it
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_rdy_nxt        = r_rdy;
        w_last_addr_nxt  = r_last_addr;
        w_last_id_nxt    = r_last_id;
        w_last_valid_nxt = r_last_valid;
        w_stall_addr_nxt = r_stall_addr;
        w_new_access     = !r_last_valid || (bus.address_bus != r_last_addr) ||
                           (w_sel_id != r_last_id);
        case (r_state)
            ST_IDLE: begin
                if ((w_sel_ws != '0) && w_new_access) begin
                    w_cnt_nxt        = w_sel_ws - WS_WIDTH'(1);
                    w_rdy_nxt        = 1'b0;
                    w_stall_addr_nxt = bus.address_bus;
                    w_state_nxt      = ST_WAIT;
                end else begin
                    w_rdy_nxt        = 1'b1;
                    w_last_addr_nxt  = bus.address_bus;
                    w_last_id_nxt    = w_sel_id;
                    w_last_valid_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.address_bus != r_stall_addr) begin
                    w_rdy_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_rdy_nxt        = 1'b1;
                    w_last_addr_nxt  = r_stall_addr;
                    w_last_id_nxt    = w_sel_id;
                    w_last_valid_nxt = 1'b1;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - WS_WIDTH'(1);
                end
            end
            default: begin
                w_rdy_nxt   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_window_address_decoder.sv
// Bench for window_address_decoder: a table of bus cycles with hand-derived
// expected ID/RDY/readback, checked through a scoreboard one phi2 edge later,
// followed by hand-written reset-mid-stall and phi2-low gating sequences.
module tb_window_address_decoder;
    import window_address_decoder_pkg::*;

    typedef struct {
        logic        rst;
        logic [15:0] addr;
        logic        rwb;
        logic [7:0]  data;
        logic [3:0]  expId;
        logic        expRdy;
        logic [7:0]  expDout;
    } vector_t;

    typedef struct {
        int          tag;
        logic [3:0]  id;
        logic        rdy;
        logic [7:0]  dout;
    } expect_t;

    logic phi2;
    logic reset;

    window_address_decoder_if #(.ID_WIDTH(4)) bus ();

    window_address_decoder dut (
        .phi2  (phi2),
        .reset (reset),
        .bus   (bus)
    );

    vector_t vectors[$];
    expect_t scoreboard[$];
    int      nVectors     = 0;
    int      nMiscompares = 0;

    // Bus clock, 10 time units per phi2 cycle
    initial begin
        phi2 = 1'b0;
        forever #5 phi2 = ~phi2;
    end

    function automatic void addVec(input logic rst, input logic [15:0] addr, input logic rwb,
                                   input logic [7:0] data, input logic [3:0] expId,
                                   input logic expRdy, input logic [7:0] expDout);
        vector_t v;
        v.rst = rst; v.addr = addr; v.rwb = rwb; v.data = data;
        v.expId = expId; v.expRdy = expRdy; v.expDout = expDout;
        vectors.push_back(v);
    endfunction

    // Drive one bus cycle during phi2 low and queue what must be seen after the rising edge
    task automatic applyStimulus(input vector_t v, input int tag);
        expect_t e;
        @(negedge phi2);
        #1;
        reset           = v.rst;
        bus.address_bus = v.addr;
        bus.rwb         = v.rwb;
        bus.data_in     = v.data;
        e.tag  = tag;
        e.id   = v.expId;
        e.rdy  = v.expRdy;
        e.dout = v.expDout;
        scoreboard.push_back(e);
    endtask

    task automatic runVec(input logic rst, input logic [15:0] addr, input logic rwb,
                          input logic [7:0] data, input logic [3:0] expId,
                          input logic expRdy, input logic [7:0] expDout, input int tag);
        vector_t v;
        v.rst = rst; v.addr = addr; v.rwb = rwb; v.data = data;
        v.expId = expId; v.expRdy = expRdy; v.expDout = expDout;
        applyStimulus(v, tag);
    endtask

    task automatic checkOutput(input expect_t e);
        logic [15:0] expEn;
        expEn = 16'(1) << e.id;
        nVectors++;
        if (bus.active_bus_device_id !== e.id) begin
            nMiscompares++;
            $display("[TB] FAIL vec%0d id: got %0d, want %0d", e.tag, bus.active_bus_device_id, e.id);
        end
        if (bus.rdy !== e.rdy) begin
            nMiscompares++;
            $display("[TB] FAIL vec%0d rdy: got %b, want %b", e.tag, bus.rdy, e.rdy);
        end
        if (bus.data_out !== e.dout) begin
            nMiscompares++;
            $display("[TB] FAIL vec%0d data_out: got %h, want %h", e.tag, bus.data_out, e.dout);
        end
        if (bus.enable_lines !== expEn) begin
            nMiscompares++;
            $display("[TB] FAIL vec%0d enable_lines: got %h, want %h", e.tag, bus.enable_lines, expEn);
        end
    endtask

    // Decode check while phi2 is still low, before the rising edge of the current cycle
    task automatic checkLow(input string name, input logic [3:0] expId, input logic [15:0] expEn);
        #2;
        nVectors++;
        if (bus.enable_lines !== expEn || bus.active_bus_device_id !== expId) begin
            nMiscompares++;
            $display("[TB] FAIL %s phi2-low: got en=%h id=%0d, want en=%h id=%0d",
                     name, bus.enable_lines, bus.active_bus_device_id, expEn, expId);
        end
    endtask

    // Scoreboard consumer: compare two time units after each rising edge
    always @(posedge phi2) begin
        #2;
        if (scoreboard.size() > 0) begin
            checkOutput(scoreboard.pop_front());
        end
    end

    initial begin
        reset           = 1'b1;
        bus.address_bus = 16'h1234;
        bus.rwb         = 1'b1;
        bus.data_in     = 8'h00;

        // rst addr     rwb data   id    rdy dout
        addVec(1, 16'h1234, 1, 8'h00, 4'd0,  1, 8'h00);
        addVec(1, 16'h1234, 1, 8'h00, 4'd0,  1, 8'h00);
        addVec(0, 16'h1234, 1, 8'h00, 4'd0,  1, 8'h00);
        addVec(0, 16'hE1F0, 1, 8'h00, 4'd15, 1, 8'h00);
        // window0: base E100, mask FFF8, ctrl 83
        addVec(0, 16'hE1F0, 0, 8'hE1, 4'd15, 1, 8'hE1);
        addVec(0, 16'hE1F1, 0, 8'h00, 4'd15, 1, 8'h00);
        addVec(0, 16'hE1F2, 0, 8'hFF, 4'd15, 1, 8'hFF);
        addVec(0, 16'hE1F3, 0, 8'hF8, 4'd15, 1, 8'hF8);
        addVec(0, 16'hE1F4, 0, 8'h83, 4'd15, 1, 8'h83);
        addVec(0, 16'hE105, 1, 8'h00, VIA_ID, 1, 8'h00);
        addVec(0, 16'hE108, 1, 8'h00, SRAM_ID, 1, 8'h00);
        addVec(0, 16'hE1F4, 1, 8'h00, 4'd15, 1, 8'h83);
        // window1: base C000, mask F000, ctrl A5 (ws=2, ID 5)
        addVec(0, 16'hE1F8, 0, 8'hC0, 4'd15, 1, 8'hC0);
        addVec(0, 16'hE1F9, 0, 8'h00, 4'd15, 1, 8'h00);
        addVec(0, 16'hE1FA, 0, 8'hF0, 4'd15, 1, 8'hF0);
        addVec(0, 16'hE1FB, 0, 8'h00, 4'd15, 1, 8'h00);
        addVec(0, 16'hE1FC, 0, 8'hA5, 4'd15, 1, 8'hA5);
        // two-cycle stall, then a held repeat does not stall
        addVec(0, 16'hC010, 1, 8'h00, 4'd5,  0, 8'h00);
        addVec(0, 16'hC010, 1, 8'h00, 4'd5,  0, 8'h00);
        addVec(0, 16'hC010, 1, 8'h00, 4'd5,  1, 8'h00);
        addVec(0, 16'hC010, 1, 8'h00, 4'd5,  1, 8'h00);
        addVec(0, 16'hC010, 1, 8'h00, 4'd5,  1, 8'h00);
        // intervening address re-arms the stall
        addVec(0, 16'h1234, 1, 8'h00, 4'd0,  1, 8'h00);
        addVec(0, 16'hC010, 1, 8'h00, 4'd5,  0, 8'h00);
        addVec(0, 16'hC010, 1, 8'h00, 4'd5,  0, 8'h00);
        addVec(0, 16'hC010, 1, 8'h00, 4'd5,  1, 8'h00);
        // address change mid-stall aborts
        addVec(0, 16'h1234, 1, 8'h00, 4'd0,  1, 8'h00);
        addVec(0, 16'hC010, 1, 8'h00, 4'd5,  0, 8'h00);
        addVec(0, 16'h1234, 1, 8'h00, 4'd0,  1, 8'h00);
        addVec(0, 16'h1234, 1, 8'h00, 4'd0,  1, 8'h00);
        // overlap: window1 moved to E000/F000, window0 wins, then window0 disabled
        addVec(0, 16'hE1F8, 0, 8'hE0, 4'd15, 1, 8'hE0);
        addVec(0, 16'hE100, 1, 8'h00, 4'd3,  1, 8'h00);
        addVec(0, 16'hE1F4, 0, 8'h03, 4'd15, 1, 8'h03);
        addVec(0, 16'hE100, 1, 8'h00, 4'd5,  0, 8'h00);
        addVec(0, 16'hE100, 1, 8'h00, 4'd5,  0, 8'h00);
        addVec(0, 16'hE100, 1, 8'h00, 4'd5,  1, 8'h00);
        // readback and reserved bytes
        addVec(0, 16'hE1F1, 0, 8'h5A, 4'd15, 1, 8'h5A);
        addVec(0, 16'hE1F1, 1, 8'h00, 4'd15, 1, 8'h5A);
        addVec(0, 16'hE1F6, 1, 8'h00, 4'd15, 1, 8'h00);
        addVec(0, 16'hE1F6, 0, 8'h77, 4'd15, 1, 8'h00);
        addVec(0, 16'hE1F6, 1, 8'h00, 4'd15, 1, 8'h00);
        // disable window1, then probe just outside / at the ends of the config range
        addVec(0, 16'hE1FC, 0, 8'h25, 4'd15, 1, 8'h25);
        addVec(0, 16'hE1EF, 1, 8'h00, 4'd0,  1, 8'h00);
        addVec(0, 16'hE210, 1, 8'h00, 4'd0,  1, 8'h00);
        addVec(0, 16'hE20F, 1, 8'h00, 4'd15, 1, 8'h00);
        // window3 with mask 0 catches everything outside the config block
        addVec(0, 16'hE20C, 0, 8'h8A, 4'd15, 1, 8'h8A);
        addVec(0, 16'h1234, 1, 8'h00, 4'd10, 1, 8'h00);
        addVec(0, 16'hE20C, 1, 8'h00, 4'd15, 1, 8'h8A);
        // window1 re-enabled beats window3
        addVec(0, 16'hE1FC, 0, 8'hA5, 4'd15, 1, 8'hA5);
        addVec(0, 16'hE100, 1, 8'h00, 4'd5,  0, 8'h00);
        addVec(0, 16'hE100, 1, 8'h00, 4'd5,  0, 8'h00);
        addVec(0, 16'hE100, 1, 8'h00, 4'd5,  1, 8'h00);
        addVec(0, 16'h1234, 1, 8'h00, 4'd10, 1, 8'h00);

        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i], i);
        end

        // Reset one cycle into a ws=3 stall: RDY released and every window cleared
        runVec(0, 16'hE1FC, 0, 8'hB5, 4'd15, 1, 8'hB5, 100);
        runVec(0, 16'hE100, 1, 8'h00, 4'd5,  0, 8'h00, 101);
        runVec(1, 16'hE100, 1, 8'h00, 4'd0,  1, 8'h00, 102);
        runVec(0, 16'hE1FC, 1, 8'h00, 4'd15, 1, 8'h00, 103);
        runVec(0, 16'hE100, 1, 8'h00, 4'd0,  1, 8'h00, 104);
        runVec(0, 16'hE20C, 1, 8'h00, 4'd15, 1, 8'h00, 105);

        // Gated SRAM enable is low while phi2 is low; the config ID is not gated
        runVec(0, 16'h1234, 1, 8'h00, 4'd0,  1, 8'h00, 106);
        checkLow("sram_gate", 4'd0, 16'h0000);
        runVec(0, 16'hE1F0, 1, 8'h00, 4'd15, 1, 8'h00, 107);
        checkLow("cfg_ungated", 4'd15, 16'h8000);

        for (int i = 0; i < 20 && scoreboard.size() > 0; i++) begin
            @(posedge phi2);
        end
        #3;
        if (scoreboard.size() > 0) begin
            nMiscompares++;
            $display("[TB] FAIL drain: %0d expectations pending, want 0", scoreboard.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
